spart_rx: RTL and testbench
===========================

# spart_rx

Serial receive engine of the SPART. Consumes the 16x-oversampled `baud_tick` enable from the baud generator, detects and validates start bits on `rxd`, and recovers 8N1 frames LSB-first by sampling each bit at its centre. Received bytes are held in a one-entry buffer with an available flag, framing-error and overrun status, all cleared by a bus read strobe.

## Interface
- `OVERSAMPLE`, default 16: baud ticks per bit period. Must be a power of two, at least 8.
- `DATA_BITS`, default 8: data bits per frame.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `baud_tick`, in, 1: single-cycle enable at OVERSAMPLE × baud rate.
- `rxd`, in, 1: asynchronous serial line. Idle is high.
- `rd_clr`, in, 1: single-cycle bus read strobe that consumes the buffered byte.
- `rx_data`, out, DATA_BITS: last received byte.
- `rda`, out, 1: receive data available.
- `framing_err`, out, 1: stop bit of the last frame was sampled low.
- `overrun`, out, 1: a byte was overwritten before it was read.
- `rx_busy`, out, 1: high in any state other than IDLE.

## Operation
- **Synchroniser.** `rxd` passes through a 2-flop synchroniser; both flops reset to 1. A third registered copy provides falling-edge detect. All logic below uses the synchronised signal.
- **State machine:** IDLE, START, DATA, STOP.
  - **IDLE:** on a synchronised falling edge (previous 1, current 0), go to START and clear the tick counter. A line held low never starts a frame; this covers break and the line staying low after a framing error.
  - **START:** each `baud_tick` increments the counter. On the tick where the counter equals OVERSAMPLE/2−1, sample the line:
    - low: go to DATA, counter=0, bit index=0;
    - high: false start, go to IDLE with no status change.
  - **DATA:** each `baud_tick` increments the counter. On the tick where the counter equals OVERSAMPLE−1, sample the line, shift it into the MSB of the shift register (right-shift, LSB-first), increment the bit index and clear the counter. After DATA_BITS samples, go to STOP.
  - **STOP:** on the tick where the counter equals OVERSAMPLE−1, sample the stop bit. Load `rx_data` from the shift register and set `rda`. Set `framing_err` to the inverse of the stop sample. Go to IDLE.
- **Counter width.** The counter is log2(OVERSAMPLE) bits and wraps naturally; no other arithmetic is needed. The bit index is clog2(DATA_BITS+1) bits.
- **Buffer and status:**
  - If a frame completes while `rda`=1 and `rd_clr`=0, set `overrun`, overwrite `rx_data`, and keep `rda`=1.
  - `rd_clr` clears `rda`, `overrun` and `framing_err`.
  - If `rd_clr` and frame completion occur in the same cycle, completion wins: `rda`=1, `framing_err` reflects the new frame, and `overrun` is cleared, not set.
  - `rd_clr` while `rda`=0 has no effect beyond clearing stale flags.
- **Ignored between ticks.** `rxd` edges between ticks in START, DATA or STOP are ignored. Only tick-aligned samples matter.
- **Reset mid-frame.** The FSM returns to IDLE and all outputs take their reset values. A frame in progress is discarded.

## Timing
- **Reset values:** `rx_data`=0, `rda`=0, `framing_err`=0, `overrun`=0, `rx_busy`=0, state IDLE, synchroniser flops=1.
- **Start detect:** START is entered 3 clk edges after the `rxd` fall: 2 synchroniser edges plus the edge-detect register.
- **Sample points,** counted in baud ticks after START entry:
  - start bit at tick OVERSAMPLE/2 (8 at default);
  - data bit k at 8+16(k+1);
  - stop bit at 152 at default.
- **Frame completion.** `rda`, `rx_data` and `framing_err` update on the same clk edge that registers the stop-sample tick. That edge also enters IDLE, so `rx_busy` drops at that edge.
- **Back-to-back frames.** The next start edge can be accepted from the cycle after STOP exits. A new falling edge needs the line to have been high, and a valid stop bit provides that.
- **Tick gaps.** `baud_tick` may be held low indefinitely. The FSM and counter freeze and are never advanced without a tick.

## Test plan
- **Single byte.** Bench ticks every 4 clk. Send 0xA5 8N1 at 16 ticks/bit. Expect `rda`=1, `rx_data`=0xA5, `framing_err`=0, `overrun`=0. Pulse `rd_clr`; expect `rda`=0 next cycle.
- **False start.** Drive a 5-tick-wide low glitch on an idle line. Expect return to IDLE after the tick-8 sample, `rda` stays 0, and a following 0x3C frame is received correctly.
- **Framing error.** Send 0x55 with the stop bit low, then hold the line low for 40 bit periods. Expect `rda`=1, `rx_data`=0x55, `framing_err`=1, and no further frame while the line stays low. Release the line high and send 0x0F; expect a clean reception.
- **Overrun.** Send 0x11 then 0x22 without `rd_clr`. Expect `rx_data`=0x22, `rda`=1, `overrun`=1. Pulse `rd_clr`; expect all three flags 0.
- **Simultaneous clear and complete.** Assert `rd_clr` in the exact cycle the second byte 0x99 completes. Expect `rda`=1, `overrun`=0, `rx_data`=0x99.
- **Reset mid-frame.** Assert `rst_n` low during data bit 3 of 0xF0. Expect all outputs at reset values and state IDLE. Release reset mid-frame; expect no spurious `rda`, then a correct 0x81 on the next full frame.

Source files
------------

// File: rtl/spart_rx.sv
// -----------------------------------------------------------------------------
// spart_rx -- serial receive engine of the SPART.
//
// Recovers 8N1 (by default) frames from rxd, LSB first. The line is oversampled
// with the baud_tick enable, and each bit is sampled once at its centre. A
// received byte is held in a one-entry buffer together with its status flags.
// A bus read strobe consumes the byte and clears the flags.
//
// Parameters
//   OVERSAMPLE  baud ticks per bit period (power of two, >= 8)
//   DATA_BITS   data bits per frame
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   baud_tick    single-cycle enable at OVERSAMPLE x baud rate
//   rxd          asynchronous serial line, idle high
//   rd_clr       single-cycle read strobe that consumes the buffered byte
//   rx_data      last received byte
//   rda          receive data available
//   framing_err  stop bit of the last frame was sampled low
//   overrun      a byte was overwritten before it was read
//   rx_busy      receiver is inside a frame (any state other than IDLE)
// -----------------------------------------------------------------------------
module spart_rx #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 baud_tick,
   input  logic                 rxd,
   input  logic                 rd_clr,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rda,
   output logic                 framing_err,
   output logic                 overrun,
   output logic                 rx_busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int IW = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);
   localparam logic [IW-1:0] LAST_IX = IW'(DATA_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state, state_nx;
   logic                 rxd_meta, rxd_sync, rxd_prev;
   logic [CW-1:0]        cnt, cnt_nx;
   logic [IW-1:0]        idx, idx_nx;
   logic [DATA_BITS-1:0] shreg, shreg_nx;
   logic                 done;

   // Two-flop synchroniser plus one extra stage for falling-edge detect. The
   // flops reset to the idle (high) level so leaving reset never looks like a
   // start edge.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, which keeps the pipeline a pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_meta <= 1'b1;
         rxd_sync <= 1'b1;
         rxd_prev <= 1'b1;
      end else begin
         rxd_meta <= rxd;
         rxd_sync <= rxd_meta;
         rxd_prev <= rxd_sync;
      end
   end

   // Next-state and datapath. Nothing moves in START/DATA/STOP without a tick,
   // so the counter freezes through tick gaps and rxd is only sampled on ticks.
   always_comb begin
      // NOTE: every variable gets a default before the case statement, so no
      // path leaves one unassigned and no latch is inferred.
      state_nx = state;
      cnt_nx   = cnt;
      idx_nx   = idx;
      shreg_nx = shreg;
      done     = 1'b0;
      unique case (state)
         IDLE: begin
            // A line that is held low never produces a fall, so break and a
            // low line after a framing error cannot start a frame.
            if (rxd_prev && !rxd_sync) begin
               state_nx = START;
               cnt_nx   = '0;
            end
         end
         START: begin
            if (baud_tick) begin
               cnt_nx = cnt + CW'(1);
               if (cnt == HALF_M1) begin
                  if (!rxd_sync) begin
                     state_nx = DATA;
                     cnt_nx   = '0;
                     idx_nx   = '0;
                  end else begin
                     state_nx = IDLE;      // glitch: false start, no status change
                  end
               end
            end
         end
         DATA: begin
            if (baud_tick) begin
               // Counter wraps to zero on the centre tick, which restarts the
               // next bit period.
               cnt_nx = cnt + CW'(1);
               if (cnt == FULL_M1) begin
                  shreg_nx = {rxd_sync, shreg[DATA_BITS-1:1]};
                  idx_nx   = idx + IW'(1);
                  if (idx == LAST_IX) state_nx = STOP;
               end
            end
         end
         STOP: begin
            if (baud_tick) begin
               cnt_nx = cnt + CW'(1);
               if (cnt == FULL_M1) begin
                  done     = 1'b1;
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         idx   <= idx_nx;
         shreg <= shreg_nx;
      end
   end

   // Receive buffer and status. A completing frame takes priority over a
   // simultaneous read: the new byte stays available and overrun is not set,
   // because the previous byte was consumed in that same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data     <= '0;
         rda         <= 1'b0;
         framing_err <= 1'b0;
         overrun     <= 1'b0;
      end else if (done) begin
         rx_data     <= shreg;
         rda         <= 1'b1;
         framing_err <= !rxd_sync;
         overrun     <= rda && !rd_clr;
      end else if (rd_clr) begin
         rda         <= 1'b0;
         framing_err <= 1'b0;
         overrun     <= 1'b0;
      end
   end

   assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_spart_rx.sv
// -----------------------------------------------------------------------------
// tb_spart_rx -- directed bench for spart_rx.
//
// baud_tick fires every 4 clk (16 ticks per bit = 64 clk per bit). Each frame
// starts on the falling clk edge just after the tick divider wraps to 0, so the
// DUT enters START at the 3rd rising edge after the fall and takes tick n on
// rising edge 4n. The stop sample (tick 152) is therefore registered on the
// 608th rising edge after the start fall, which lets the bench place rd_clr in
// exactly that cycle.
// -----------------------------------------------------------------------------
module tb_spart_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rxd = 1'b1;
   logic       rd_clr = 1'b0;
   logic       tick_en = 1'b1;
   logic [1:0] tdiv = 2'd0;
   logic       baud_tick;
   logic [7:0] rx_data;
   logic       rda, framing_err, overrun, rx_busy;

   int nvec = 0;
   int nerr = 0;

   localparam int BITCLK = 64;
   localparam int FRAME  = 10 * BITCLK;
   localparam int DONE_M = 608;

   spart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rxd(rxd), .rd_clr(rd_clr),
      .rx_data(rx_data), .rda(rda), .framing_err(framing_err), .overrun(overrun),
      .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) tdiv <= tdiv + 2'd1;
   assign baud_tick = tick_en && (tdiv == 2'd3);

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time (vectors=%0d)", nvec);
      $fatal(1, "watchdog expired");
   end

   // Frame bit for clk offset m: start, 8 data bits LSB first, stop.
   function automatic logic frame_bit(input logic [7:0] d, input logic stop_bit, input int m);
      int b;
      b = m / BITCLK;
      if (b == 0) return 1'b0;
      if (b == 9) return stop_bit;
      return d[b-1];
   endfunction

   // Wait for the falling clk edge right after the tick divider wraps to 0.
   task automatic align();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (tdiv == 2'd0) return;
      end
   endtask

   // Drive one whole frame; optionally pulse rd_clr in the stop-sample cycle.
   // Returns with rxd still at the stop level.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic clr_at_done);
      align();
      for (int m = 0; m < FRAME; m++) begin
         if (m > 0) @(negedge clk);
         rxd    = frame_bit(d, stop_bit, m);
         rd_clr = clr_at_done && (m == DONE_M - 1);
      end
      rd_clr = 1'b0;
   endtask

   task automatic idle_clks(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_clr();
      @(negedge clk) rd_clr = 1'b1;
      @(negedge clk) rd_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      nvec++; if (rx_data !== 8'h00) begin nerr++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
      nvec++; if ({rda, framing_err, overrun, rx_busy} !== 4'b0000) begin nerr++; $display("FAIL reset_flags: got %b want 0000", {rda, framing_err, overrun, rx_busy}); end
      rst_n = 1'b1;
      idle_clks(8);
   endtask

   task automatic test_single_byte();
      send_frame(8'hA5, 1'b1, 1'b0);
      idle_clks(2);
      nvec++; if (rx_data !== 8'hA5) begin nerr++; $display("FAIL single_data: got %h want a5", rx_data); end
      nvec++; if ({rda, framing_err, overrun, rx_busy} !== 4'b1000) begin nerr++; $display("FAIL single_flags: got %b want 1000", {rda, framing_err, overrun, rx_busy}); end
      pulse_clr();
      nvec++; if (rda !== 1'b0) begin nerr++; $display("FAIL single_clr: rda got %b want 0", rda); end
      idle_clks(BITCLK);
   endtask

   task automatic test_false_start();
      align();
      rxd = 1'b0;
      repeat (10) @(negedge clk);
      nvec++; if (rx_busy !== 1'b1) begin nerr++; $display("FAIL glitch_start: rx_busy got %b want 1", rx_busy); end
      repeat (10) @(negedge clk);
      rxd = 1'b1;
      repeat (20) @(negedge clk);
      nvec++; if ({rda, rx_busy} !== 2'b00) begin nerr++; $display("FAIL glitch_idle: {rda,busy} got %b want 00", {rda, rx_busy}); end
      idle_clks(BITCLK);
      send_frame(8'h3C, 1'b1, 1'b0);
      idle_clks(2);
      nvec++; if ({rx_data, rda, framing_err} !== {8'h3C, 2'b10}) begin nerr++; $display("FAIL glitch_next: got %h/%b%b want 3c/10", rx_data, rda, framing_err); end
      pulse_clr();
      idle_clks(BITCLK);
   endtask

   task automatic test_framing_error();
      send_frame(8'h55, 1'b0, 1'b0);
      repeat (40 * BITCLK) @(negedge clk);   // line stays low
      nvec++; if ({rx_data, rda, framing_err, overrun} !== {8'h55, 3'b110}) begin nerr++; $display("FAIL ferr_status: got %h/%b%b%b want 55/110", rx_data, rda, framing_err, overrun); end
      nvec++; if (rx_busy !== 1'b0) begin nerr++; $display("FAIL ferr_low_line: rx_busy got %b want 0", rx_busy); end
      idle_clks(BITCLK);
      pulse_clr();
      nvec++; if ({rda, framing_err} !== 2'b00) begin nerr++; $display("FAIL ferr_clr: got %b want 00", {rda, framing_err}); end
      send_frame(8'h0F, 1'b1, 1'b0);
      idle_clks(2);
      nvec++; if ({rx_data, rda, framing_err, overrun} !== {8'h0F, 3'b100}) begin nerr++; $display("FAIL ferr_recover: got %h/%b%b%b want 0f/100", rx_data, rda, framing_err, overrun); end
      pulse_clr();
      idle_clks(BITCLK);
   endtask

   task automatic test_overrun();
      send_frame(8'h11, 1'b1, 1'b0);
      idle_clks(BITCLK);
      send_frame(8'h22, 1'b1, 1'b0);
      idle_clks(2);
      nvec++; if ({rx_data, rda, overrun, framing_err} !== {8'h22, 3'b110}) begin nerr++; $display("FAIL overrun_set: got %h/%b%b%b want 22/110", rx_data, rda, overrun, framing_err); end
      pulse_clr();
      nvec++; if ({rda, overrun, framing_err} !== 3'b000) begin nerr++; $display("FAIL overrun_clr: got %b want 000", {rda, overrun, framing_err}); end
      idle_clks(BITCLK);
   endtask

   task automatic test_back_to_back_clear();
      send_frame(8'h77, 1'b1, 1'b0);
      send_frame(8'h99, 1'b1, 1'b1);          // no idle gap; rd_clr at completion
      idle_clks(2);
      nvec++; if ({rx_data, rda, overrun} !== {8'h99, 2'b10}) begin nerr++; $display("FAIL clr_vs_done: got %h/%b%b want 99/10", rx_data, rda, overrun); end
      pulse_clr();
      idle_clks(BITCLK);
   endtask

   task automatic test_tick_gap();
      tick_en = 1'b0;
      align();
      rxd = 1'b1;
      @(negedge clk) rxd = 1'b0;
      repeat (300) @(negedge clk);
      nvec++; if (rx_busy !== 1'b1) begin nerr++; $display("FAIL gap_frozen: rx_busy got %b want 1", rx_busy); end
      rxd = 1'b1;
      tick_en = 1'b1;
      repeat (BITCLK) @(negedge clk);
      nvec++; if ({rda, rx_busy} !== 2'b00) begin nerr++; $display("FAIL gap_false_start: {rda,busy} got %b want 00", {rda, rx_busy}); end
      idle_clks(BITCLK);
   endtask

   task automatic test_reset_mid_frame();
      send_frame(8'h5A, 1'b1, 1'b0);          // leave a byte buffered
      idle_clks(BITCLK);
      align();
      for (int m = 0; m < FRAME; m++) begin
         if (m > 0) @(negedge clk);
         rxd = frame_bit(8'hF0, 1'b1, m);
         if (m == 288) rst_n = 1'b0;          // middle of data bit 3
         if (m == 292) begin
            nvec++; if ({rx_data, rda, framing_err, overrun, rx_busy} !== {8'h00, 4'b0000}) begin nerr++; $display("FAIL rst_mid: got %h/%b want 00/0000", rx_data, {rda, framing_err, overrun, rx_busy}); end
         end
         if (m == 320) rst_n = 1'b1;
      end
      idle_clks(BITCLK);
      nvec++; if ({rda, rx_busy} !== 2'b00) begin nerr++; $display("FAIL rst_no_spurious: {rda,busy} got %b want 00", {rda, rx_busy}); end
      send_frame(8'h81, 1'b1, 1'b0);
      idle_clks(2);
      nvec++; if ({rx_data, rda, framing_err, overrun} !== {8'h81, 3'b100}) begin nerr++; $display("FAIL rst_next: got %h/%b%b%b want 81/100", rx_data, rda, framing_err, overrun); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_false_start();
      test_framing_error();
      test_overrun();
      test_back_to_back_clear();
      test_tick_gap();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
